jtframe_rom_nslot: RTL
======================

JTFRAME_ROM_NSLOT -- requirements
Module: jtframe_rom_nslot

Interface
REQ-001 SHALL have parameter SLOTS, default 4, number of read slots (1..8).
REQ-002 SHALL have parameter SAW, default 22, SDRAM word-address width.
REQ-003 SHALL have parameter DW, default 16, SDRAM/slot data width.
REQ-004 SHALL have parameter OFFSETS, default all zero, SLOTS*SAW packed per-slot base word address; slot i occupies [i*SAW +: SAW].
REQ-005 SHALL have port clk  in  1  sole clock; rising edge.
REQ-006 SHALL have port rstb  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port downloading  in  1  ROM download in progress.
REQ-008 SHALL have port slot_cs  in  SLOTS  per-slot read request.
REQ-009 SHALL have port slot_addr  in  SLOTS*SAW  per-slot word address, relative to slot base.
REQ-010 SHALL have port slot_ok  out  SLOTS  per-slot data valid for current address.
REQ-011 SHALL have port slot_dout  out  SLOTS*DW  per-slot cached data.
REQ-012 SHALL have port sdram_req  out  1  SDRAM read request, level.
REQ-013 SHALL have port sdram_ack  in  1  request accepted, one-cycle pulse.
REQ-014 SHALL have port sdram_addr  out  SAW  absolute read address.
REQ-015 SHALL have port data_rdy  in  1  read data valid, one-cycle pulse.
REQ-016 SHALL have port data_read  in  DW  SDRAM read data.

Function
REQ-017 SHALL keep per slot a one-entry cache: tag (SAW), data (DW), valid bit.
REQ-018 SHALL drive slot_ok[i] = slot_cs[i] & valid[i] & (tag[i]==slot_addr[i]), combinational from registers; slot_dout[i] = data[i] always.
REQ-019 SHALL treat slot i as pending when slot_cs[i] is high and slot_ok[i] is low and downloading is low.
REQ-020 SHALL implement states IDLE, WAIT_ACK, WAIT_DATA.
REQ-021 SHALL, in IDLE with any slot pending, latch the granted slot index and its slot_addr, set sdram_addr = slot_addr + OFFSET (modulo 2^SAW), assert sdram_req on the next cycle, and enter WAIT_ACK.
REQ-022 SHALL hold sdram_req and sdram_addr stable in WAIT_ACK; on sdram_ack deassert sdram_req the following cycle and enter WAIT_DATA.
REQ-023 SHALL, in WAIT_DATA on data_rdy, write data_read and the latched address into the granted slot's data/tag, set its valid bit, and return to IDLE.
REQ-024 SHALL accept sdram_ack and data_rdy in the same cycle in WAIT_ACK as a complete transaction (write cache, go to IDLE).
REQ-025 SHALL ignore data_rdy outside WAIT_DATA/WAIT_ACK and sdram_ack outside WAIT_ACK.
REQ-026 SHALL complete an in-flight read if slot_cs drops or slot_addr changes; the stored tag is the latched address, so a changed address yields slot_ok low and a new request.
REQ-027 SHALL, when downloading rises, return to IDLE, drop sdram_req within one cycle, and clear all valid bits; no requests while downloading is high.
REQ-028 SHALL give best-case miss-to-ok latency of 3 cycles plus SDRAM ack/data latency.

Reset
REQ-029 SHALL on rstb low: state IDLE, sdram_req 0, sdram_addr 0, all valid/tag/data 0, grant index 0, round-robin pointer 0; slot_ok therefore all 0.

Configuration
REQ-030 SHALL, with JTFRAME_ROM_RR_EN defined, grant round-robin starting at the slot after the last granted one.
REQ-031 SHALL, without JTFRAME_ROM_RR_EN, grant fixed priority, lowest slot index first.

Structure
REQ-032 SHALL place state encoding and SLOTS maximum constant in package jtframe_rom_pkg.
REQ-033 SHALL implement the grant logic as sub-module jtframe_rom_arb (pending vector, last grant in; one-hot grant and index out).

Verification
REQ-034 SHALL test: reset, slot0 cs with addr 0x10, OFFSETS slot0=0x1000 -> sdram_addr 0x1010, ack, data_rdy with 0xBEEF -> slot_ok[0]=1, slot_dout[0]=0xBEEF.
REQ-035 SHALL test: repeated cs at same addr after hit -> no new sdram_req; addr change to 0x11 -> slot_ok falls same cycle, new request issued.
REQ-036 SHALL test: slots 1 and 3 pending together -> fixed mode serves 1 then 3; RR mode after grant 3 with 0,1 pending serves 0 then 1.
REQ-037 SHALL test: addr changes during WAIT_DATA -> cache holds old tag, slot_ok stays 0, second request with new address.
REQ-038 SHALL test: downloading asserted in WAIT_ACK -> sdram_req 0 next cycle, all slot_ok 0, no request until downloading drops.
REQ-039 SHALL test: rstb asserted mid-transaction -> all outputs at reset values immediately, late data_rdy ignored.

Source files
------------

// File: rtl/jtframe_rom_pkg.sv
// jtframe_rom_pkg: shared state encoding, slot limit and index-width helper for the ROM slot cache
package jtframe_rom_pkg;

    localparam int SLOTS_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } state_t;

    // Slot index width; a single slot still gets one bit so vectors stay legal
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb: picks one pending slot; fixed priority by default, round-robin with JTFRAME_ROM_RR_EN
module jtframe_rom_arb
    import jtframe_rom_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int IW    = idx_w(SLOTS)
)(
    input  logic [SLOTS-1:0] pending,
    input  logic [IW-1:0]    last,
    output logic [SLOTS-1:0] gnt,
    output logic [IW-1:0]    gnt_idx
);

`ifdef JTFRAME_ROM_RR_EN
    localparam int RR = 1;
`else
    localparam int RR = 0;
`endif

    // Scan the wrap order backwards so the first pending slot in search order wins
    always_comb begin
        gnt_idx = '0;
        gnt     = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (pending[(k + RR * (int'(last) + 1)) % SLOTS])
                gnt_idx = IW'((k + RR * (int'(last) + 1)) % SLOTS);
        end
        gnt[gnt_idx] = |pending;
    end

endmodule

// File: rtl/jtframe_rom_nslot.sv
// jtframe_rom_nslot: N read slots with one-entry caches sharing one SDRAM read port (JTFRAME_ROM_RR_EN selects round-robin)
module jtframe_rom_nslot
    import jtframe_rom_pkg::*;
#(
    parameter int                   SLOTS   = 4,
    parameter int                   SAW     = 22,
    parameter int                   DW      = 16,
    parameter logic [SLOTS*SAW-1:0] OFFSETS = '0
)(
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 downloading,
    input  logic [SLOTS-1:0]     slot_cs,
    input  logic [SLOTS*SAW-1:0] slot_addr,
    output logic [SLOTS-1:0]     slot_ok,
    output logic [SLOTS*DW-1:0]  slot_dout,
    output logic                 sdram_req,
    input  logic                 sdram_ack,
    output logic [SAW-1:0]       sdram_addr,
    input  logic                 data_rdy,
    input  logic [DW-1:0]        data_read
);

    localparam int IW = idx_w(SLOTS);

    if (SLOTS < 1 || SLOTS > SLOTS_MAX) begin : g_slots_range
        $error("jtframe_rom_nslot: SLOTS out of range");
    end

    state_t           state;
    logic [SLOTS-1:0] valid;
    logic [SLOTS-1:0] pending;
    logic [SLOTS-1:0] arb_gnt;
    logic [SAW-1:0]   tag  [SLOTS];
    logic [DW-1:0]    data [SLOTS];
    logic [SAW-1:0]   lat_addr;
    logic [SAW-1:0]   req_addr;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    arb_idx;
    logic             fill;

    // Hit test per slot straight from the cache registers
    always_comb begin
        slot_ok   = '0;
        slot_dout = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_ok[i]            = slot_cs[i] & valid[i] & (tag[i] == slot_addr[i*SAW +: SAW]);
            slot_dout[i*DW +: DW] = data[i];
        end
    end

    assign pending  = slot_cs & ~slot_ok & {SLOTS{~downloading}};
    assign req_addr = slot_addr[int'(arb_idx)*SAW +: SAW];
    // Data may arrive together with the ack, which closes the transaction early
    assign fill     = data_rdy & ((state == WAIT_DATA) | ((state == WAIT_ACK) & sdram_ack));

    jtframe_rom_arb #(
        .SLOTS   (SLOTS),
        .IW      (IW)
    ) u_arb (
        .pending (pending),
        .last    (gnt_idx),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Request FSM and cache fill; a download flushes every slot and aborts the read
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            lat_addr   <= '0;
            gnt_idx    <= '0;
            valid      <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else if (downloading) begin
            state     <= IDLE;
            sdram_req <= 1'b0;
            valid     <= '0;
        end else begin
            if (fill) begin
                data[gnt_idx]  <= data_read;
                tag[gnt_idx]   <= lat_addr;
                valid[gnt_idx] <= 1'b1;
            end
            case (state)
                IDLE: if (|arb_gnt) begin
                    gnt_idx    <= arb_idx;
                    lat_addr   <= req_addr;
                    sdram_addr <= req_addr + OFFSETS[int'(arb_idx)*SAW +: SAW];
                    sdram_req  <= 1'b1;
                    state      <= WAIT_ACK;
                end
                WAIT_ACK: if (sdram_ack) begin
                    sdram_req <= 1'b0;
                    state     <= data_rdy ? IDLE : WAIT_DATA;
                end
                WAIT_DATA: if (data_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
